// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry instruction FIFO between fetch and decode,
// with empty-queue bypass into the ID register and a highest-priority flush.
module if_id_queue #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_inst,
    output logic              if_ready,
    input  logic [5:0]        stall,
    input  logic              flush,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic [DATA_W-1:0] r_mem_inst [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_id_valid;
    logic [ADDR_W-1:0] r_id_pc;
    logic [DATA_W-1:0] r_id_inst;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_advance;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_unused_stall;

    always_comb begin
        w_full         = (r_count == CNT_W'(DEPTH));
        w_empty        = (r_count == '0);
        w_accept       = if_valid && !w_full && !flush;
        w_advance      = !stall[2];
        w_bypass       = w_advance && w_empty && w_accept;
        w_push         = w_accept && !w_bypass;
        w_pop          = w_advance && !w_empty;
        w_unused_stall = ^{stall[5:3], stall[1:0]};
    end

    // Storage array carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= if_pc;
            r_mem_inst[r_wr_ptr] <= if_inst;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_inst  <= '0;
        end else if (flush) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_inst  <= '0;
        end else if (w_advance) begin
            if (!w_empty) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= r_mem_pc[r_rd_ptr];
                r_id_inst  <= r_mem_inst[r_rd_ptr];
            end else if (w_bypass) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= if_pc;
                r_id_inst  <= if_inst;
            end else begin
                r_id_valid <= 1'b0;
                r_id_pc    <= '0;
                r_id_inst  <= '0;
            end
        end
    end

    assign if_ready = !w_full;
    assign id_valid = r_id_valid;
    assign id_pc    = r_id_pc;
    assign id_inst  = r_id_inst;
    assign count    = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed table-driven bench for if_id_queue plus async-reset and wrap-around sequences.
module tb_if_id_queue;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 3;

    logic              clk;
    logic              rst;
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_inst;
    logic              if_ready;
    logic [5:0]        stall;
    logic              flush;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [DATA_W-1:0] id_inst;
    logic [CNT_W-1:0]  count;

    int n_tests;
    int n_fail;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        st;
        logic        fl;
        logic        ev;
        logic [31:0] epc;
        int          ecnt;
        logic        erdy;
    } vec_t;

    vec_t vecs[64];
    int   n_vecs;

    if_id_queue #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .if_valid(if_valid),
        .if_pc   (if_pc),
        .if_inst (if_inst),
        .if_ready(if_ready),
        .stall   (stall),
        .flush   (flush),
        .id_valid(id_valid),
        .id_pc   (id_pc),
        .id_inst (id_inst),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return (pc == 32'h0) ? 32'h0 : (32'hDEAD0000 | pc);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic add(input logic v, input logic [31:0] pc, input logic st, input logic fl,
                       input logic ev, input logic [31:0] epc, input int ecnt,
                       input logic erdy);
        vecs[n_vecs] = '{v, pc, st, fl, ev, epc, ecnt, erdy};
        n_vecs++;
    endtask

    // Unused stall bits are driven to junk so they are shown to be ignored.
    task automatic drive(input logic v, input logic [31:0] pc, input logic st, input logic fl);
        if_valid = v;
        if_pc    = pc;
        if_inst  = mk_inst(pc);
        stall    = {3'b101, st, 2'b11};
        flush    = fl;
    endtask

    initial begin
        int sent;
        int recv;
        logic acc;
        logic st;
        n_tests = 0;
        n_fail  = 0;
        n_vecs  = 0;
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Idle after reset
        repeat (3) add(0, 32'h000, 0, 0, 0, 32'h000, 0, 1);
        // Bypass
        add(1, 32'h100, 0, 0, 1, 32'h100, 0, 1);
        add(1, 32'h104, 0, 0, 1, 32'h104, 0, 1);
        add(1, 32'h108, 0, 0, 1, 32'h108, 0, 1);
        add(0, 32'h000, 0, 0, 0, 32'h000, 0, 1);
        // Fill while stalled; fifth beat refused
        add(1, 32'h200, 1, 0, 0, 32'h000, 1, 1);
        add(1, 32'h204, 1, 0, 0, 32'h000, 2, 1);
        add(1, 32'h208, 1, 0, 0, 32'h000, 3, 1);
        add(1, 32'h20C, 1, 0, 0, 32'h000, 4, 0);
        add(1, 32'h210, 1, 0, 0, 32'h000, 4, 0);
        // Drain in order, then bubble
        add(0, 32'h000, 0, 0, 1, 32'h200, 3, 1);
        add(0, 32'h000, 0, 0, 1, 32'h204, 2, 1);
        add(0, 32'h000, 0, 0, 1, 32'h208, 1, 1);
        add(0, 32'h000, 0, 0, 1, 32'h20C, 0, 1);
        add(0, 32'h000, 0, 0, 0, 32'h000, 0, 1);
        // Simultaneous push/pop
        add(1, 32'h300, 1, 0, 0, 32'h000, 1, 1);
        add(1, 32'h304, 1, 0, 0, 32'h000, 2, 1);
        add(1, 32'h308, 0, 0, 1, 32'h300, 2, 1);
        add(0, 32'h000, 0, 0, 1, 32'h304, 1, 1);
        add(0, 32'h000, 0, 0, 1, 32'h308, 0, 1);
        // Flush with count=3, id_valid=1, stalled, beat present
        add(1, 32'h600, 1, 0, 1, 32'h308, 1, 1);
        add(1, 32'h604, 1, 0, 1, 32'h308, 2, 1);
        add(1, 32'h608, 1, 0, 1, 32'h308, 3, 1);
        add(1, 32'h400, 1, 1, 0, 32'h000, 0, 1);
        add(1, 32'h500, 0, 0, 1, 32'h500, 0, 1);
        add(0, 32'h000, 0, 0, 0, 32'h000, 0, 1);
        // Flush while advancing with a non-empty queue
        add(1, 32'h700, 1, 0, 0, 32'h000, 1, 1);
        add(1, 32'h704, 0, 1, 0, 32'h000, 0, 1);

        #1;
        check("in_reset_count", 32'(count), 32'd0);
        check("in_reset_ready", 32'(if_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < n_vecs; i++) begin
            drive(vecs[i].v, vecs[i].pc, vecs[i].st, vecs[i].fl);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 32'(id_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d_pc", i), id_pc, vecs[i].epc);
            check($sformatf("v%0d_inst", i), id_inst, mk_inst(vecs[i].epc));
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
            check($sformatf("v%0d_ready", i), 32'(if_ready), 32'(vecs[i].erdy));
        end

        // Async reset between edges with count=3 and id_valid=1
        drive(1'b1, 32'h6F0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h710 + 32'(4 * i), 1'b1, 1'b0);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_valid", 32'(id_valid), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_valid", 32'(id_valid), 32'd0);
        check("async_rst_pc", id_pc, 32'd0);
        check("async_rst_ready", 32'(if_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Wrap-around: 10 beats through the queue with intermittent stalls
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 80 && recv < 10; cyc++) begin
            st = ((cyc % 5) == 1) || ((cyc % 5) == 2) || ((cyc % 5) == 3) || (cyc < 6);
            drive(sent < 10, 32'h800 + 32'(4 * sent), st, 1'b0);
            acc = if_valid && if_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (!st && id_valid) begin
                check($sformatf("wrap_pc%0d", recv), id_pc, 32'h800 + 32'(4 * recv));
                check($sformatf("wrap_inst%0d", recv), id_inst, mk_inst(32'h800 + 32'(4 * recv)));
                recv++;
            end
        end
        check("wrap_received", 32'(recv), 32'd10);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("wrap_final_count", 32'(count), 32'd0);
        check("wrap_final_valid", 32'(id_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
